tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the DVI encoder/generator path: decodes one TMDS channel.
- Input: raw 10-bit parallel words from an external deserializer, arbitrary bit phase.
- Finds word alignment by searching for runs of control tokens, then reverses the TMDS transition-minimisation encoding.
- Outputs pixel byte, control bits and de in the pixel clock domain.
- Three instances (ch0/ch1/ch2) feed a future capture/framebuffer writer.

---
 rtl/tmds_channel_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// Receive-side decoder for one TMDS channel. The raw 10-bit words come from an
// external deserializer and can be at any bit phase. The block finds word
// alignment by hunting for runs of control tokens. Once aligned, it undoes the
// transition-minimising encoding.
// Pipeline: cur/prev capture -> window register (q) -> decoded outputs.
// A word whose first bit lands in raw_word at clock edge N is presented on
// data/c/de after edge N+3, whatever the bit offset.
// Optional build macro TMDS_LOSS_CNT_EN adds the loss_cnt output. That output
// counts LOCKED->SEARCH transitions and saturates at 255.
module tmds_channel_decoder #(
    parameter int CTRL_RUN     = 8,
    parameter int SLIP_WAIT    = 2048,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_word,
    output logic [7:0] data,
    output logic [1:0] c,
    output logic       de,
    output logic       locked,
`ifdef TMDS_LOSS_CNT_EN
    output logic [7:0] loss_cnt,
`endif
    output logic [3:0] offset
);

    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int TMR_W = $clog2(SLIP_WAIT + 1);
    localparam int GAP_W = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SLIP_WAIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Returns {hit, C1, C0}; hit=0 for any non-token word.
    function automatic logic [2:0] token_decode(input logic [9:0] q);
        case (q)
            10'b1101010100: token_decode = 3'b100;
            10'b0010101011: token_decode = 3'b101;
            10'b0101010100: token_decode = 3'b110;
            10'b1010101011: token_decode = 3'b111;
            default:        token_decode = 3'b000;
        endcase
    endfunction

    // Undo the optional inversion (q[9]), then the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] data_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] r;
        d    = q[9] ? ~q[7:0] : q[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return r;
    endfunction

    logic [9:0]       r_cur, r_prev, r_q;
    logic [3:0]       r_offset, w_offset_nxt;
    logic [RUN_W-1:0] r_run, w_run_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [1:0]       r_flush, w_flush_nxt;
    state_t           r_state, w_state_nxt;
    logic [19:0]      w_stream;
    logic [9:0]       w_window;
    logic [2:0]       w_tok;
    logic [7:0]       w_dec;
    logic             w_lock_nxt;
    logic [7:0]       r_data;
    logic [1:0]       r_c;
    logic             r_de, r_locked;

    assign w_stream   = {r_cur, r_prev};
    assign w_tok      = token_decode(r_q);
    assign w_dec      = data_decode(r_q);
    assign w_lock_nxt = (w_state_nxt == ST_LOCKED);

    // Select the 10-bit window that starts r_offset bits into the older word.
    always_comb begin
        w_window = w_stream[9:0];
        case (r_offset)
            4'd0:    w_window = w_stream[9:0];
            4'd1:    w_window = w_stream[10:1];
            4'd2:    w_window = w_stream[11:2];
            4'd3:    w_window = w_stream[12:3];
            4'd4:    w_window = w_stream[13:4];
            4'd5:    w_window = w_stream[14:5];
            4'd6:    w_window = w_stream[15:6];
            4'd7:    w_window = w_stream[16:7];
            4'd8:    w_window = w_stream[17:8];
            4'd9:    w_window = w_stream[18:9];
            default: w_window = w_stream[9:0];
        endcase
    end

    // Capture raw words and register the aligned window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur  <= 10'd0;
            r_prev <= 10'd0;
            r_q    <= 10'd0;
        end else begin
            r_cur  <= raw_word;
            r_prev <= r_cur;
            r_q    <= w_window;
        end
    end

    // Alignment FSM: next state and counters. Lock beats a simultaneous slip.
    always_comb begin
        w_state_nxt  = r_state;
        w_run_nxt    = r_run;
        w_timer_nxt  = r_timer;
        w_gap_nxt    = r_gap;
        w_offset_nxt = r_offset;
        w_flush_nxt  = r_flush;
        case (r_state)
            ST_SEARCH: begin
                w_gap_nxt = {GAP_W{1'b0}};
                if (w_tok[2] && (r_flush == 2'd0) && (r_run == RUN_LAST)) begin
                    w_state_nxt = ST_LOCKED;
                    w_run_nxt   = {RUN_W{1'b0}};
                    w_timer_nxt = {TMR_W{1'b0}};
                end else if (r_timer >= TMR_LAST) begin
                    w_offset_nxt = (r_offset >= 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_timer_nxt  = {TMR_W{1'b0}};
                    w_run_nxt    = {RUN_W{1'b0}};
                    w_flush_nxt  = 2'd2;
                end else begin
                    w_timer_nxt = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + TMR_W'(1);
                    if (r_flush != 2'd0) begin
                        // q still holds words windowed at the old offset
                        w_flush_nxt = r_flush - 2'd1;
                        w_run_nxt   = {RUN_W{1'b0}};
                    end else if (w_tok[2]) begin
                        w_run_nxt = (r_run == {RUN_W{1'b1}}) ? r_run : r_run + RUN_W'(1);
                    end else begin
                        w_run_nxt = {RUN_W{1'b0}};
                    end
                end
            end
            ST_LOCKED: begin
                w_run_nxt   = {RUN_W{1'b0}};
                w_timer_nxt = {TMR_W{1'b0}};
                w_flush_nxt = 2'd0;
                if (w_tok[2]) begin
                    w_gap_nxt = {GAP_W{1'b0}};
                end else if (r_gap >= GAP_LAST) begin
                    w_state_nxt = ST_SEARCH;
                    w_gap_nxt   = {GAP_W{1'b0}};
                end else begin
                    w_gap_nxt = (r_gap == {GAP_W{1'b1}}) ? r_gap : r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_run_nxt   = {RUN_W{1'b0}};
                w_timer_nxt = {TMR_W{1'b0}};
                w_gap_nxt   = {GAP_W{1'b0}};
                w_flush_nxt = 2'd0;
            end
        endcase
    end

    // Alignment FSM state and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_SEARCH;
            r_run    <= {RUN_W{1'b0}};
            r_timer  <= {TMR_W{1'b0}};
            r_gap    <= {GAP_W{1'b0}};
            r_offset <= 4'd0;
            r_flush  <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= w_run_nxt;
            r_timer  <= w_timer_nxt;
            r_gap    <= w_gap_nxt;
            r_offset <= w_offset_nxt;
            r_flush  <= w_flush_nxt;
        end
    end

    // Output stage: tokens update c, data words update data; zero while unlocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data   <= 8'd0;
            r_c      <= 2'd0;
            r_de     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_locked <= w_lock_nxt;
            if (!w_lock_nxt) begin
                r_data <= 8'd0;
                r_c    <= 2'd0;
                r_de   <= 1'b0;
            end else if (w_tok[2]) begin
                r_de <= 1'b0;
                r_c  <= w_tok[1:0];
            end else begin
                r_de   <= 1'b1;
                r_data <= w_dec;
            end
        end
    end

`ifdef TMDS_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Count lock losses; saturates and is cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_loss_cnt <= 8'd0;
        end else if ((r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH) &&
                     (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end else begin
            r_loss_cnt <= r_loss_cnt;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

    assign data   = r_data;
    assign c      = r_c;
    assign de     = r_de;
    assign locked = r_locked;
    assign offset = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed testbench for tmds_channel_decoder: lock, slip search, decode, loss of lock, reset.
module tb_tmds_channel_decoder;

    localparam int CTRL_RUN     = 8;
    localparam int SLIP_WAIT    = 16;
    localparam int LOSS_TIMEOUT = 32;

    localparam logic [9:0] TOK0 = 10'h354;  // 1101010100 -> c=00
    localparam logic [9:0] TOK1 = 10'h0AB;  // 0010101011 -> c=01
    localparam logic [9:0] TOK2 = 10'h154;  // 0101010100 -> c=10
    localparam logic [9:0] TOK3 = 10'h2AB;  // 1010101011 -> c=11
    localparam logic [9:0] DW   = 10'h0AA;  // decodes to 8'h00

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] raw_word = 10'h000;
    logic [7:0] data;
    logic [1:0] c;
    logic       de;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int         n_vec  = 0;
    int         n_miss = 0;
    int         dly    = 0;          // channel bit delay applied by send()
    logic [9:0] tx_prev = 10'h000;

    // Decode table: transmitted word and expected {de, c, data} three words later.
    logic [9:0]  vec_tbl [10] = '{10'h00F, 10'h0AA, 10'h255, 10'h1F0, 10'h30F,
                                  TOK1,     10'h00F, TOK2,     TOK3,     TOK0};
    logic [10:0] exp_tbl [10] = '{{1'b1, 2'b00, 8'hEF}, {1'b1, 2'b00, 8'h00},
                                  {1'b1, 2'b00, 8'h00}, {1'b1, 2'b00, 8'h10},
                                  {1'b1, 2'b00, 8'h10}, {1'b0, 2'b01, 8'h10},
                                  {1'b1, 2'b01, 8'hEF}, {1'b0, 2'b10, 8'hEF},
                                  {1'b0, 2'b11, 8'hEF}, {1'b0, 2'b00, 8'hEF}};

    tmds_channel_decoder #(
        .CTRL_RUN     (CTRL_RUN),
        .SLIP_WAIT    (SLIP_WAIT),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_word (raw_word),
        .data     (data),
        .c        (c),
        .de       (de),
        .locked   (locked),
`ifdef TMDS_LOSS_CNT_EN
        .loss_cnt (loss_cnt),
`endif
        .offset   (offset)
    );

    // Pixel clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit one TMDS word through a channel that delays the bit stream by dly bits.
    task automatic send(input logic [9:0] w);
        logic [19:0] s;
        s        = {w, tx_prev} >> (10 - dly);
        raw_word = s[9:0];
        tx_prev  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_locked"}, 16'(locked), 16'h0000);
        check_val({tag, "_de"},     16'(de),     16'h0000);
        check_val({tag, "_data"},   16'(data),   16'h0000);
        check_val({tag, "_c"},      16'(c),      16'h0000);
        check_val({tag, "_offset"}, 16'(offset), 16'h0000);
    endtask

    // Main directed sequence.
    initial begin
        #2;
        check_idle("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Aligned lock: the 8th token sent locks on the 11th edge.
        repeat (10) send(TOK0);
        check_val("lock_early", 16'(locked), 16'h0000);
        send(TOK0);
        check_val("lock_on",     16'(locked), 16'h0001);
        check_val("lock_c",      16'(c),      16'h0000);
        check_val("lock_de",     16'(de),     16'h0000);
        check_val("lock_offset", 16'(offset), 16'h0000);

        // Decode table, outputs three edges after each word.
        for (int i = 0; i < 13; i++) begin
            send((i < 10) ? vec_tbl[i] : TOK0);
            if (i == 2) check_val("dec_latency_de", 16'(de), 16'h0000);
            if (i >= 3) check_val($sformatf("dec%0d", i - 3), 16'({de, c, data}), 16'(exp_tbl[i - 3]));
        end

        // A token as the LOSS_TIMEOUT-th word keeps lock.
        repeat (LOSS_TIMEOUT - 1) send(DW);
        send(TOK0);
        repeat (LOSS_TIMEOUT - 1) send(DW);
        repeat (3) send(TOK0);
        check_val("gap_saved", 16'(locked), 16'h0001);

        // LOSS_TIMEOUT data words drop lock when the last one is processed.
        repeat (LOSS_TIMEOUT + 2) send(DW);
        check_val("loss_early", 16'(locked), 16'h0001);
        send(DW);
        check_idle("loss");

        // Relock, then reset mid-stream.
        repeat (11) send(TOK0);
        check_val("relock", 16'(locked), 16'h0001);
        send(10'h00F);
        repeat (3) send(TOK0);
        check_val("pre_rst_data", 16'(data), 16'h00EF);
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) send(TOK0);
        check_val("rst_relock_early", 16'(locked), 16'h0000);
        send(TOK0);
        check_val("rst_relock", 16'(locked), 16'h0001);

        // Slip search with a 3-bit channel delay.
        rst = 1'b0;
        @(posedge clk);
        #1;
        dly     = 3;
        tx_prev = TOK0;
        rst     = 1'b1;
        for (int e = 1; e <= 58; e++) begin
            send(TOK0);
            if (e == 15) check_val("slip_off0", 16'(offset), 16'h0000);
            if (e == 16) check_val("slip_off1", 16'(offset), 16'h0001);
            if (e == 30) check_val("slip_de",   16'(de),     16'h0000);
            if (e == 31) check_val("slip_off1b", 16'(offset), 16'h0001);
            if (e == 32) check_val("slip_off2", 16'(offset), 16'h0002);
            if (e == 48) check_val("slip_off3", 16'(offset), 16'h0003);
            if (e == 57) check_val("slip_lock_early", 16'(locked), 16'h0000);
            if (e == 58) begin
                check_val("slip_lock", 16'(locked), 16'h0001);
                check_val("slip_c",    16'(c),      16'h0000);
                check_val("slip_de_l", 16'(de),     16'h0000);
            end
        end
        repeat (40) send(TOK0);
        check_val("slip_hold_off",  16'(offset), 16'h0003);
        check_val("slip_hold_lock", 16'(locked), 16'h0001);
        send(10'h00F);
        repeat (3) send(TOK0);
        check_val("slip_dec", 16'({de, data}), 16'h01EF);
        send(TOK2);
        repeat (3) send(TOK0);
        check_val("slip_tok2", 16'({de, c, data}), 16'h02EF);

        // Loss at offset 3 keeps the offset, then relocks there.
        repeat (LOSS_TIMEOUT + 2) send(DW);
        check_val("loss3_early", 16'(locked), 16'h0001);
        send(DW);
        check_val("loss3_lock",   16'(locked), 16'h0000);
        check_val("loss3_offset", 16'(offset), 16'h0003);
        repeat (11) send(TOK0);
        check_val("relock3",     16'(locked), 16'h0001);
        check_val("relock3_off", 16'(offset), 16'h0003);
        send(10'h00F);
        repeat (3) send(TOK0);
        rst = 1'b0;
        #1;
        check_idle("rst_off3");
        @(posedge clk);
        #1;
        dly     = 0;
        tx_prev = TOK0;
        rst     = 1'b1;

`ifdef TMDS_LOSS_CNT_EN
        check_val("loss_cnt_rst", 16'(loss_cnt), 16'h0000);
        for (int k = 0; k < 300; k++) begin
            repeat (12) send(TOK0);
            repeat (LOSS_TIMEOUT + 3) send(DW);
            if (k == 2) check_val("loss_cnt3", 16'(loss_cnt), 16'h0003);
        end
        check_val("loss_cnt_sat", 16'(loss_cnt), 16'h00FF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
